// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-requester round-robin mux arbiter.
// Optional lock feature is selected with the MUX8_RR_LOCK_EN macro.
package mux8_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ = 8;
  localparam int SELW = 3;

  // Reset value of the "last owner" pointer: 7 makes requester 0 first.
  localparam logic [SELW-1:0] LAST_RST = 3'd7;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer bundle for mux8_rr_arbiter.
// With MUX8_RR_LOCK_EN defined the bundle also carries the lock input.
//
// Handshake: a requester holds req[k] high (with its data on din) for as
// long as it wants the channel; gnt[k] is the arbiter's answer and a word is
// transferred on every cycle where the owner's req is still high. The
// registered copy appears on y one cycle later, qualified by valid.
interface mux8_rr_arbiter_if
  import mux8_arb_pkg::*;
#(
  parameter int DW = 4
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [SELW-1:0]    sel;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      y;
  logic               valid;
  logic               busy;
  state_t             state;   // debug view of the arbiter FSM
`ifdef MUX8_RR_LOCK_EN
  logic               lock;
`endif

`ifdef MUX8_RR_LOCK_EN
  modport master (output req, din, lock, input sel, gnt, y, valid, busy, state);
  modport slave  (input req, din, lock, output sel, gnt, y, valid, busy, state);
`else
  modport master (output req, din, input sel, gnt, y, valid, busy, state);
  modport slave  (input req, din, output sel, gnt, y, valid, busy, state);
`endif

endinterface

// File: rtl/mux8_rr_arbiter_dw.sv
// Combinational 8:1 word mux: picks requester sel's slice out of packed din.
module mux8_dw
  import mux8_arb_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [SELW-1:0]    sel,
  input  logic [NREQ*DW-1:0] din,
  output logic [DW-1:0]      y
);

  // Slice select of the chosen requester's word
  always_comb begin
    y = din[sel*DW +: DW];
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sequencing an 8:1 DW-bit mux with a bounded hold time.
// Optional lock input enabled by MUX8_RR_LOCK_EN: while locked, the owner
// keeps the channel past MAX_HOLD (release on req drop still applies).
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int DW       = 4,
  parameter int MAX_HOLD = 4,
  parameter int HCW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux8_rr_arbiter_if.slave   bus
);

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [SELW-1:0] last_q, last_d;
  logic [DW-1:0]   y_q, y_d;
  logic            valid_q, valid_d;

  logic [DW-1:0]   mux_y;
  logic            owner_req;
  logic            lock_hold;
  logic            at_limit;
  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic [SELW-1:0] pick_start;

  // First set request at or after start, ascending with wrap.
  // Returns {found, index}.
  function automatic logic [SELW:0] rr_pick(logic [NREQ-1:0] r,
                                            logic [SELW-1:0] start);
    logic            found;
    logic [SELW-1:0] win;
    logic [SELW-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = start + SELW'(i);
      if (r[idx] && !found) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  mux8_dw #(.DW(DW)) u_mux (
    .sel (sel_q),
    .din (bus.din),
    .y   (mux_y)
  );

  // Release qualifiers and arbitration search from the current owner/last
  always_comb begin
    owner_req = bus.req[sel_q];
`ifdef MUX8_RR_LOCK_EN
    lock_hold = bus.lock && owner_req;
`else
    lock_hold = 1'b0;
`endif
    at_limit  = (hold_cnt_q == HOLD_LAST);
    // In IDLE the search begins after last; on a release it begins after
    // the releasing owner, which becomes the new last.
    pick_start = (state_q == GRANT) ? sel_q + 3'd1 : last_q + 3'd1;
    {pick_found, pick_idx} = rr_pick(bus.req, pick_start);
  end

  // FSM next-state and grant/hold bookkeeping
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          sel_d      = pick_idx;
          gnt_d      = NREQ'(1) << pick_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!owner_req || (at_limit && !lock_hold)) begin
          last_d     = sel_q;
          hold_cnt_d = '0;
          if (pick_found) begin
            sel_d = pick_idx;
            gnt_d = NREQ'(1) << pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          // Saturates only when locked past the limit
          hold_cnt_d = at_limit ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output word path: capture the owner's word on every live grant cycle
  always_comb begin
    valid_d = (state_q == GRANT) && owner_req;
    y_d     = valid_d ? mux_y : y_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      hold_cnt_q <= '0;
      last_q     <= LAST_RST;
      y_q        <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
    end
  end

  // Drive the bundle outputs straight from the flops
  always_comb begin
    bus.sel   = sel_q;
    bus.gnt   = gnt_q;
    bus.y     = y_q;
    bus.valid = valid_q;
    bus.busy  = (state_q == GRANT);
    bus.state = state_q;
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios followed by
// randomized request/data traffic, checked against an ownership model.
// Defining MUX8_RR_LOCK_EN also exercises the lock input.
module tb_mux8_rr_arbiter;
  import mux8_arb_pkg::*;

  localparam int DW       = 4;
  localparam int MAX_HOLD = 4;
  localparam int HCW      = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux8_rr_arbiter_if #(.DW(DW)) bif ();

  mux8_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD), .HCW(HCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // Tracks who owns the channel and for how many cycles they have had it.
  int          m_owner;   // -1 when nobody owns the channel
  int          m_tenure;  // cycles the current owner has held it (1-based)
  int          m_last;    // most recent owner to give the channel up
  int          m_sel;
  logic [DW-1:0] m_y;
  logic        m_valid;
  logic        cur_lock;

  function automatic int pick_after(logic [7:0] r, int after);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (after + k) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_tenure = 0;
    m_last   = 7;
    m_sel    = 0;
    m_y      = '0;
    m_valid  = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [31:0] d, input logic lk);
    int  w;
    logic done;
    m_valid = (m_owner >= 0) && r[m_owner];
    if (m_valid) m_y = d[m_owner*DW +: DW];
    if (m_owner < 0) begin
      w = pick_after(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_tenure = 1;
      end
    end else begin
      done = !r[m_owner] || (m_tenure >= MAX_HOLD && !(lk && r[m_owner]));
      if (done) begin
        m_last = m_owner;
        w = pick_after(r, m_owner);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_tenure = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_tenure < MAX_HOLD) begin
        m_tenure++;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string phase);
    logic [7:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    check({phase, ".gnt"},   bif.gnt,          exp_gnt);
    check({phase, ".sel"},   8'(bif.sel),      8'(m_sel));
    check({phase, ".y"},     8'(bif.y),        8'(m_y));
    check({phase, ".valid"}, 8'(bif.valid),    8'(m_valid));
    check({phase, ".busy"},  8'(bif.busy),     8'(m_owner >= 0));
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input string phase, input logic [7:0] r, input logic [31:0] d);
    bif.req = r;
    bif.din = d;
`ifdef MUX8_RR_LOCK_EN
    bif.lock = cur_lock;
`endif
    model_step(r, d, cur_lock);
    @(posedge clk);
    @(negedge clk);
    check_all(phase);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  r;
    logic [31:0] d;
    int          seg;
    rst_n    = 1'b0;
    cur_lock = 1'b0;
    bif.req  = '0;
    bif.din  = '0;
`ifdef MUX8_RR_LOCK_EN
    bif.lock = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    do_reset();

    // Single requester 3 with word A, persisting past several hold windows
    for (int i = 0; i < 12; i++) cycle("single", 8'h08, 32'h0000_A000 | ($urandom & 32'hFFFF_0FFF));
    // Sole requester drops: back to idle, y holds
    for (int i = 0; i < 3; i++) cycle("idle", 8'h00, $urandom);

    // Full rotation from requester 0
    do_reset();
    for (int i = 0; i < 36; i++) cycle("rotate", 8'hFF, $urandom);

    // Reset in the middle of a grant
    do_reset();
    cycle("post_rst", 8'hFF, $urandom);
    cycle("post_rst", 8'hFF, $urandom);

    // Early release: owner 2 drops after 2 cycles, grant moves to 5
    do_reset();
    cycle("early", 8'h24, $urandom);
    cycle("early", 8'h24, $urandom);
    cycle("early", 8'h20, $urandom);
    cycle("early", 8'h20, $urandom);
    cycle("early", 8'h00, $urandom);
    cycle("early", 8'h00, $urandom);

`ifdef MUX8_RR_LOCK_EN
    // Owner 1 locks with everyone requesting, then unlocks
    do_reset();
    cycle("lock", 8'h02, $urandom);
    cur_lock = 1'b1;
    for (int i = 0; i < 10; i++) cycle("lock", 8'hFF, $urandom);
    cur_lock = 1'b0;
    for (int i = 0; i < 3; i++) cycle("lock", 8'hFF, $urandom);
`endif

    // Randomized traffic with requests held for short segments
    for (int s = 0; s < 120; s++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'(1 << $urandom_range(0, 7));
        1:       r = 8'h00;
        default: r = 8'($urandom_range(0, 255));
      endcase
`ifdef MUX8_RR_LOCK_EN
      cur_lock = ($urandom_range(0, 3) == 0);
`endif
      seg = $urandom_range(1, 6);
      for (int k = 0; k < seg; k++) begin
        d = $urandom;
        if ($urandom_range(0, 4) == 0) r = r ^ 8'(1 << $urandom_range(0, 7));
        cycle("random", r, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
